sbox_layer_serial: RTL and testbench

Parametrised, multi-cycle QARMAv2 S-box layer. It applies the forward S-box (sigma_rho) or the inverse S-box to every 4-bit cell of an NIBBLES-cell state, and processes LANES cells per clock. Area can be traded against latency without changing the cipher datapath. The block sits between the round-key/tweak mixing stage and the permutation/MixColumns stage, and uses valid/ready handshakes on both sides.

---
 rtl/sbox_layer_serial.sv | 131 +++++++++++++
 tb/tb_sbox_layer_serial.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sbox_layer_serial.sv
// sbox_layer_serial: multi-cycle QARMAv2 S-box layer (forward sigma_rho or inverse).
// Substitutes LANES 4-bit cells per clock over an NIBBLES-cell state, with
// valid/ready handshakes on the input and output sides.
module sbox_layer_serial #(
  parameter int NIBBLES = 32,
  parameter int LANES   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_inverse,
  input  logic [4*NIBBLES-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_data,
  output logic                   busy
);

  localparam int BEATS = NIBBLES / LANES;
  localparam int W     = 4 * NIBBLES;
  localparam int LW    = 4 * LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (NIBBLES < 1 || LANES < 1 || (NIBBLES % LANES) != 0) begin : g_bad_params
    $error("sbox_layer_serial: need NIBBLES >= 1, LANES >= 1 and LANES dividing NIBBLES");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h4;  4'h1: y = 4'h7;  4'h2: y = 4'h9;  4'h3: y = 4'hB;
      4'h4: y = 4'hC;  4'h5: y = 4'h6;  4'h6: y = 4'hE;  4'h7: y = 4'hF;
      4'h8: y = 4'h0;  4'h9: y = 4'h5;  4'hA: y = 4'h1;  4'hB: y = 4'hD;
      4'hC: y = 4'h8;  4'hD: y = 4'h3;  4'hE: y = 4'h2;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h8;  4'h1: y = 4'hA;  4'h2: y = 4'hE;  4'h3: y = 4'hD;
      4'h4: y = 4'h0;  4'h5: y = 4'h9;  4'h6: y = 4'h5;  4'h7: y = 4'h1;
      4'h8: y = 4'hC;  4'h9: y = 4'h2;  4'hA: y = 4'hF;  4'hB: y = 4'h3;
      4'hC: y = 4'h4;  4'hD: y = 4'hB;  4'hE: y = 4'h6;  default: y = 4'h7;
    endcase
    return y;
  endfunction

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    data_q, data_d;
  logic            mode_q;
  logic            in_ready_q, out_valid_q, busy_q;
  logic [LW-1:0]   lanes_sub;

  // S-box the LANES lowest cells of the working register under the latched mode
  always_comb begin
    lanes_sub = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lanes_sub[4*l +: 4] = mode_q ? sbox_inv(data_q[4*l +: 4]) : sbox_fwd(data_q[4*l +: 4]);
    end
  end

  // The register rotates right by LANES cells each beat, the substituted cells
  // re-entering at the top; after BEATS beats every cell is back in place,
  // substituted once, lowest first. Keeps all selects constant.
  if (BEATS == 1) begin : g_one_beat
    assign data_d = lanes_sub;
  end else begin : g_multi_beat
    assign data_d = {lanes_sub, data_q[W-1:LW]};
  end

  // Control FSM with registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            data_q     <= in_data;
            mode_q     <= in_inverse;
            cnt_q      <= '0;
            state_q    <= S_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          data_q <= data_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(BEATS - 1)) begin
            cnt_q       <= '0;
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_sbox_layer_serial.sv
// Testbench for sbox_layer_serial: directed vector table, backpressure,
// mid-run reset, random round trip and a NIBBLES=16 lane sweep.
`timescale 1ns/1ps
module tb_sbox_layer_serial;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_inverse = 1'b0, out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;

  logic         sw_valid = 1'b0;
  logic [63:0]  sw_data = '0;
  logic         s_ir[3], s_ov[3], s_busy[3];
  logic [63:0]  s_od[3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sbox_layer_serial u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inverse(in_inverse), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  sbox_layer_serial #(.NIBBLES(16), .LANES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s_ir[0]),
    .in_inverse(1'b0), .in_data(sw_data), .out_valid(s_ov[0]),
    .out_ready(1'b1), .out_data(s_od[0]), .busy(s_busy[0])
  );
  sbox_layer_serial #(.NIBBLES(16), .LANES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s_ir[1]),
    .in_inverse(1'b0), .in_data(sw_data), .out_valid(s_ov[1]),
    .out_ready(1'b1), .out_data(s_od[1]), .busy(s_busy[1])
  );
  sbox_layer_serial #(.NIBBLES(16), .LANES(16)) u_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s_ir[2]),
    .in_inverse(1'b0), .in_data(sw_data), .out_valid(s_ov[2]),
    .out_ready(1'b1), .out_data(s_od[2]), .busy(s_busy[2])
  );

  // Reference tables written out from the cipher definition
  logic [3:0] FWD [16] = '{4'h4, 4'h7, 4'h9, 4'hB, 4'hC, 4'h6, 4'hE, 4'hF,
                           4'h0, 4'h5, 4'h1, 4'hD, 4'h8, 4'h3, 4'h2, 4'hA};
  logic [3:0] INV [16] = '{4'h8, 4'hA, 4'hE, 4'hD, 4'h0, 4'h9, 4'h5, 4'h1,
                           4'hC, 4'h2, 4'hF, 4'h3, 4'h4, 4'hB, 4'h6, 4'h7};

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[4*i +: 4] = inv ? INV[d[4*i +: 4]] : FWD[d[4*i +: 4]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All tasks are entered #1 after a rising edge
  task automatic accept(input logic inv, input logic [127:0] d);
    int guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    in_valid = 1'b1; in_inverse = inv; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0; in_inverse = ~inv;
    in_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_main(input logic inv, input logic [127:0] d,
                          output logic [127:0] q, output int lat);
    accept(inv, d);
    wait_valid(lat);
    q = out_valid ? out_data : 'x;
    handshake();
  endtask

  typedef struct {
    string        name;
    logic         inv;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  initial begin
    vec_t         vecs[5];
    logic [127:0] q, q2, hold, r;
    int           lat;
    int           slat[3];
    logic [63:0]  sdat[3];

    vecs[0] = '{"fwd_zero", 1'b0, 128'h0, {32{4'h4}}};
    vecs[1] = '{"fwd_count", 1'b0, 128'h0123456789ABCDEF0123456789ABCDEF,
                128'h479BC6EF051D832A479BC6EF051D832A};
    vecs[2] = '{"inv_count", 1'b1, 128'h479BC6EF051D832A479BC6EF051D832A,
                128'h0123456789ABCDEF0123456789ABCDEF};
    vecs[3] = '{"inv_all4", 1'b1, {32{4'h4}}, 128'h0};
    vecs[4] = '{"fwd_allF", 1'b0, {32{4'hF}}, {32{4'hA}}};

    // Reset state
    #12;
    chk("reset_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("reset_data", out_data, 128'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    foreach (vecs[i]) begin
      run_main(vecs[i].inv, vecs[i].din, q, lat);
      chk({vecs[i].name, "_data"}, q, vecs[i].exp);
      chk({vecs[i].name, "_latency"}, 128'(lat), 128'(8));
      chk({vecs[i].name, "_post_hs_ready"}, 128'({in_ready, out_valid, busy}), 128'(3'b100));
    end

    // Backpressure: result held, inputs ignored, single handshake
    accept(1'b0, 128'h0123456789ABCDEF0123456789ABCDEF);
    wait_valid(lat);
    hold = out_data;
    chk("bp_data", hold, 128'h479BC6EF051D832A479BC6EF051D832A);
    in_valid = 1'b1; in_inverse = 1'b1; in_data = {4{32'hDEADBEEF}};
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", out_data, hold);
      chk("bp_hold_flags", 128'({in_ready, out_valid, busy}), 128'(3'b011));
    end
    in_valid = 1'b0;
    handshake();
    chk("bp_after_hs", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    @(posedge clk); #1;
    chk("bp_idle_stays", 128'({in_ready, out_valid, busy}), 128'(3'b100));

    // Reset asserted during beat 3 of RUN
    accept(1'b0, 128'h0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("midrst_data", out_data, 128'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_main(1'b0, 128'h0, q, lat);
    chk("midrst_rerun_data", q, {32{4'h4}});
    chk("midrst_rerun_latency", 128'(lat), 128'(8));

    // Random forward-then-inverse round trip
    for (int n = 0; n < 1000; n++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      run_main(1'b0, r, q, lat);
      chk("rand_fwd", q, model(r, 1'b0));
      run_main(1'b1, q, q2, lat);
      chk("rand_roundtrip", q2, r);
    end

    // Lane sweep at NIBBLES=16
    sw_data = 64'hFEDCBA9876543210;
    sw_valid = 1'b1;
    @(posedge clk); #1;
    sw_valid = 1'b0;
    sw_data = 64'h0;
    for (int k = 0; k < 3; k++) begin slat[k] = -1; sdat[k] = '0; end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
        if (s_ov[k] && slat[k] < 0) begin slat[k] = c; sdat[k] = s_od[k]; end
    end
    chk("sweep_l1_data", 128'(sdat[0]), 128'h0000000000000000A238D150FE6CB974);
    chk("sweep_l1_latency", 128'(slat[0]), 128'(16));
    chk("sweep_l4_data", 128'(sdat[1]), 128'h0000000000000000A238D150FE6CB974);
    chk("sweep_l4_latency", 128'(slat[1]), 128'(4));
    chk("sweep_l16_data", 128'(sdat[2]), 128'h0000000000000000A238D150FE6CB974);
    chk("sweep_l16_latency", 128'(slat[2]), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
